// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and mux select, plus the 2-bit ALUOp for the ALU controller.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instr at PC, load IR/OldPC, PC <= PC + 4
// DECODE   | ALUOut <= OldPC + B-imm (speculative branch target)
// EXEC_R   | ALUOut <= RD1 op RD2
// EXEC_I   | ALUOut <= RD1 op I-imm
// ALU_WB   | rd <= ALUOut
// MEM_ADDR | ALUOut <= RD1 + I/S-imm
// MEM_RD   | Data <= mem[ALUOut]
// MEM_WB   | rd <= Data
// MEM_WR   | mem[ALUOut] <= RD2
// BRANCH   | compare RD1/RD2, PC <= ALUOut if taken
// JAL      | PC <= OldPC + J-imm
// JALR     | PC <= RD1 + I-imm
// LINK     | rd <= OldPC + 4
// LUI      | rd <= U-imm
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       zero,
    input  logic       neg,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [1:0] ALUOp,
    output logic       RegWrite
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_taken;
    logic w_pcwrite;
    logic w_memwrite;
    logic w_irwrite;
    logic w_regwrite;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_next;
    end

    always_comb begin
        w_taken = 1'b0;
        case (func3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = ~zero;
            3'b100:  w_taken = neg;
            3'b101:  w_taken = ~neg;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next     = S_FETCH;
        w_pcwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 3'b000;
        ALUOp      = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b010;
                case (opcode)
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
                    OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
                    OP_BR:             w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    default:           w_next = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                w_next  = S_ALU_WB;
            end
            S_EXEC_I: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b11;
                w_next  = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_regwrite = 1'b1;
            end
            S_MEM_ADDR: begin
                // IR still holds the instruction, so opcode picks load vs store here
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                if (opcode == OP_STORE) begin
                    ImmSrc = 3'b001;
                    w_next = S_MEM_WR;
                end else begin
                    w_next = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                AdrSrc = 1'b1;
                w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            S_MEM_WR: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUOp     = 2'b01;
                w_pcwrite = w_taken;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b01;
                ImmSrc    = 3'b011;
                ResultSrc = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_LINK;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_LINK;
            end
            S_LINK: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                w_regwrite = 1'b1;
            end
            S_LUI: begin
                ImmSrc     = 3'b100;
                ResultSrc  = 2'b11;
                w_regwrite = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Gated by reset so an interrupted instruction can never complete a write
    assign PCWrite  = w_pcwrite  & rst;
    assign MemWrite = w_memwrite & rst;
    assign IRWrite  = w_irwrite  & rst;
    assign RegWrite = w_regwrite & rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus side pushes the expected control word
// for every cycle of each instruction, and a monitor pops and compares mid-cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] func3 = 3'd0;
    logic       zero = 1'b0;
    logic       neg = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .zero(zero), .neg(neg),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUOp(ALUOp), .RegWrite(RegWrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] exp;
        logic [15:0] mask;
        int          tag;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Word layout: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUOp RegWrite
    localparam logic [15:0] MASK_ALL = 16'hFFFF;
    localparam logic [15:0] MASK_WE  = 16'hB001;

    function automatic logic [15:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [2:0] imm,
                                       input logic [1:0] op, input logic rw);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, op, rw};
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return n;
            3'b101:  return !n;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_t e;
                logic [15:0] got;
                e   = sb_q.pop_front();
                got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                       ImmSrc, ALUOp, RegWrite};
                checks++;
                if (((got ^ e.exp) & e.mask) != 16'h0) begin
                    errors++;
                    $display("FAIL ctlword instr=%0d cyc=%0d got=%h exp=%h mask=%h",
                             e.tag, e.cyc, got, e.exp, e.mask);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        rst  = 1'b1;
        zero = 1'($urandom & 1);
        neg  = 1'($urandom & 1);
    endtask

    task automatic push(input logic [15:0] w, input logic [15:0] m, input int tag, input int cyc);
        exp_t e;
        e.exp = w; e.mask = m; e.tag = tag; e.cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic hold_reset(input int n, input int tag);
        for (int i = 0; i < n; i++) begin
            step();
            rst = 1'b0;
            push(16'h0000, MASK_WE, tag, i);
        end
    endtask

    // One instruction, FETCH through its last state; force_zn pins zero/neg in BRANCH
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int tag,
                             input bit force_zn, input logic fz, input logic fn);
        step(); opcode = op; func3 = f3;
        push(mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0), MASK_ALL, tag, 1);
        step();
        push(mk(0,0,0,0,2'b00,2'b01,2'b01,3'b010,2'b00,0), MASK_ALL, tag, 2);
        case (op)
            7'b0110011, 7'b0010011: begin
                step();
                if (op == 7'b0110011) push(mk(0,0,0,0,2'b00,2'b10,2'b00,3'b000,2'b10,0), MASK_ALL, tag, 3);
                else                  push(mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b11,0), MASK_ALL, tag, 3);
                step(); push(mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1), MASK_ALL, tag, 4);
            end
            7'b0000011: begin
                step(); push(mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0), MASK_ALL, tag, 3);
                step(); push(mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0), MASK_ALL, tag, 4);
                step(); push(mk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b00,1), MASK_ALL, tag, 5);
            end
            7'b0100011: begin
                step(); push(mk(0,0,0,0,2'b00,2'b10,2'b01,3'b001,2'b00,0), MASK_ALL, tag, 3);
                step(); push(mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b00,0), MASK_ALL, tag, 4);
            end
            7'b1100011: begin
                step();
                if (force_zn) begin zero = fz; neg = fn; end
                push(mk(branch_taken(f3, zero, neg),0,0,0,2'b00,2'b10,2'b00,3'b000,2'b01,0),
                     MASK_ALL, tag, 3);
            end
            7'b1101111, 7'b1100111: begin
                step();
                if (op == 7'b1101111) push(mk(1,0,0,0,2'b10,2'b01,2'b01,3'b011,2'b00,0), MASK_ALL, tag, 3);
                else                  push(mk(1,0,0,0,2'b10,2'b10,2'b01,3'b000,2'b00,0), MASK_ALL, tag, 3);
                step(); push(mk(0,0,0,0,2'b10,2'b01,2'b10,3'b000,2'b00,1), MASK_ALL, tag, 4);
            end
            7'b0110111: begin
                step(); push(mk(0,0,0,0,2'b11,2'b00,2'b00,3'b100,2'b00,1), MASK_ALL, tag, 3);
            end
            default: ;
        endcase
    endtask

    // Store interrupted by reset in MEM_WR: the write must never appear
    task automatic store_abort(input int tag);
        step(); opcode = 7'b0100011; func3 = 3'($urandom);
        push(mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0), MASK_ALL, tag, 1);
        step();
        push(mk(0,0,0,0,2'b00,2'b01,2'b01,3'b010,2'b00,0), MASK_ALL, tag, 2);
        step();
        push(mk(0,0,0,0,2'b00,2'b10,2'b01,3'b001,2'b00,0), MASK_ALL, tag, 3);
        hold_reset(3, tag);
    endtask

    logic [6:0] legal_ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

    initial begin
        logic [6:0] op;
        hold_reset(3, 0);
        store_abort(1);
        run_instr(7'b0110011, 3'd0, 2, 0, 0, 0);
        run_instr(7'b0000011, 3'd2, 3, 0, 0, 0);
        run_instr(7'b0100011, 3'd2, 4, 0, 0, 0);
        run_instr(7'b1100011, 3'b000, 5, 1, 1, 0);
        run_instr(7'b1100011, 3'b001, 6, 1, 1, 0);
        run_instr(7'b1100011, 3'b100, 7, 1, 0, 1);
        run_instr(7'b1100011, 3'b010, 8, 1, 1, 1);
        run_instr(7'b1101111, 3'd0, 9, 0, 0, 0);
        run_instr(7'b0000000, 3'd0, 10, 0, 0, 0);
        run_instr(7'b0010011, 3'd0, 11, 0, 0, 0);
        run_instr(7'b1100111, 3'd0, 12, 0, 0, 0);
        run_instr(7'b0110111, 3'd0, 13, 0, 0, 0);
        for (int i = 0; i < 200; i++) begin
            if (i % 40 == 39) begin
                store_abort(100 + i);
            end else begin
                if ($urandom_range(9, 0) < 8) op = legal_ops[$urandom_range(7, 0)];
                else                          op = 7'($urandom);
                run_instr(op, 3'($urandom), 100 + i, 0, 0, 0);
            end
        end
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM of the multicycle RV32I datapath. It sits directly upstream of the ALU controller.
- Decodes the opcode held in the instruction register, sequences fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select.
- Produces the 2-bit ALUOp that the ALU controller combines with func3/func7 to form ALUControl.

Parameters:
- None. Opcodes, state codes and select encodings are fixed constants.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  synchronous reset, active-low; sampled on rising clk
- opcode  input  7  instr[6:0] from the instruction register
- func3  input  3  instr[14:12]; selects the branch condition
- zero  input  1  ALU result == 0
- neg  input  1  ALU result sign bit (SLT-style less-than)
- PCWrite  output  1  PC load enable
- AdrSrc  output  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  load IR and OldPC
- ResultSrc  output  2  00 = ALUOut, 01 = Data reg, 10 = ALUResult, 11 = Imm
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  output  2  00 = RD2, 01 = Imm, 10 = constant 4
- ImmSrc  output  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- ALUOp  output  2  00 = add (S_T), 01 = sub (B_T), 10 = R-type, 11 = I-type
- RegWrite  output  1  register file write enable

Behaviour:
- One clock, `clk`. Reset `rst` is synchronous and active-low.
- State encoding is 4-bit. Every output is 0 unless listed for the current state.
- Outputs are Moore, except PCWrite in BRANCH.
- While `rst` = 0:
  - the state register loads FETCH on each edge;
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 regardless of state;
  - the first FETCH executes on the first edge with `rst` = 1.
- Reset mid-instruction abandons the instruction. No partial write may occur after `rst` falls.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=010, ALUOp=00, so ALUOut = branch target. Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - any other opcode -> FETCH, as a silent no-op
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALU_WB.
- EXEC_I: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUOp=11. Next state ALU_WB.
- ALU_WB: ResultSrc=00, RegWrite=1. Next state FETCH.
- MEM_ADDR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - ImmSrc=000 for load, 001 for store.
  - Next state MEM_RD for load, MEM_WR for store.
- MEM_RD: AdrSrc=1. Next state MEM_WB.
- MEM_WB: ResultSrc=01, RegWrite=1. Next state FETCH.
- MEM_WR: AdrSrc=1, MemWrite=1. Next state FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite=taken, where taken is:
  - func3 000: zero
  - func3 001: ~zero
  - func3 100: neg
  - func3 101: ~neg
  - any other func3: 0
  - Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=01, ImmSrc=011, ALUOp=00, ResultSrc=10, PCWrite=1. Next state LINK.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUOp=00, ResultSrc=10, PCWrite=1. Next state LINK.
  - rs1 is read before rd is written, so rd == rs1 is safe.
- LINK: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=10, RegWrite=1, so rd = OldPC + 4. Next state FETCH.
- LUI: ImmSrc=100, ResultSrc=11, RegWrite=1. Next state FETCH.
- Latency in cycles, FETCH to FETCH:
  - R-type 4, I-type 4, load 5, store 4
  - branch 3, jal 4, jalr 4, lui 3, illegal opcode 2
- At most one of RegWrite, MemWrite and IRWrite is high in any cycle.
- zero and neg are ignored outside BRANCH.

Test Plan:
- `rst`=0 for 3 cycles, with state forced mid-MEM_WR before the first reset edge -> MemWrite=0 from that edge on; FETCH asserts IRWrite=1 and PCWrite=1 on the first cycle after `rst`=1.
- opcode 0110011 -> 4-cycle sequence with ALUOp 00,00,10,xx; RegWrite=1 only in cycle 4.
- opcode 0000011 -> 5 cycles; AdrSrc=1 in cycle 4; cycle 5 has ResultSrc=01 and RegWrite=1.
- opcode 0100011 -> MemWrite=1 in cycle 4 only, with ImmSrc=001 in cycle 3; RegWrite stays 0 throughout.
- opcode 1100011 in BRANCH:
  - func3=000, zero=1 -> PCWrite=1
  - func3=001, zero=1 -> PCWrite=0
  - func3=100, neg=1 -> PCWrite=1
  - func3=010 -> PCWrite=0
  - every case returns to FETCH after 3 cycles with ALUOp=01 in BRANCH.
- opcode 1101111, then 0000000 -> JAL gives PCWrite=1 in cycle 3 and RegWrite=1 in cycle 4; the illegal opcode returns DECODE -> FETCH with no write enables asserted.
